// File: rtl/acc_pkg.sv
// Shared widths, slice-count derivation and FSM encodings for the conv accelerator input path.
// Pure definitions: no logic, no latency, no flow control.
package acc_pkg;

    localparam int INPUT_WIDTH  = 512;
    localparam int OUTPUT_WIDTH = 64;
    localparam int MAX_CNT      = INPUT_WIDTH / OUTPUT_WIDTH;
    localparam int LEN_W        = 16;
    localparam int CNT_W        = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int TOT_W        = LEN_W + CNT_W;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE   = 2'd0;
    localparam fsm_state_t ST_PRIME  = 2'd1;
    localparam fsm_state_t ST_STREAM = 2'd2;
    localparam fsm_state_t ST_DONE   = 2'd3;

    // Sized so a full-length frame of MAX_CNT slices per word cannot overflow.
    function automatic logic [TOT_W-1:0] total_slices(input logic [LEN_W-1:0] len);
        return TOT_W'(len) * TOT_W'(MAX_CNT);
    endfunction

endpackage

// File: rtl/ifm_fetch_ctrl_if.sv
// Bundle between the stream source/parser side (master) and the fetch sequencer (slave).
// Wires only: no latency; s_tready carries the stream backpressure.
interface ifm_fetch_ctrl_if;
    import acc_pkg::*;

    logic                   conv_start;
    logic [LEN_W-1:0]       num_words;
    logic [INPUT_WIDTH-1:0] s_tdata;
    logic                   s_tvalid;
    logic                   s_tready;
    logic                   pe_ready;
    logic [INPUT_WIDTH-1:0] fm;
    logic                   init_word;
    logic                   ifm_read;
    logic                   busy;
    logic                   done;

    modport master (
        output conv_start, num_words, s_tdata, s_tvalid, pe_ready,
        input  s_tready, fm, init_word, ifm_read, busy, done
    );

    modport slave (
        input  conv_start, num_words, s_tdata, s_tvalid, pe_ready,
        output s_tready, fm, init_word, ifm_read, busy, done
    );

endinterface

// File: rtl/ifm_word_buf.sv
// Current-word register feeding the parser plus a one-deep prefetch slot.
// Loads take effect next cycle; caller withholds nxt_ld_i while the slot is full unless advancing.
module ifm_word_buf
    import acc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   prime_ld_i,
    input  logic                   nxt_ld_i,
    input  logic                   adv_i,
    input  logic [INPUT_WIDTH-1:0] in_dat_i,
    output logic [INPUT_WIDTH-1:0] cur_o,
    output logic                   nxt_v_o
);

    logic [INPUT_WIDTH-1:0] cur_q, cur_d;
    logic [INPUT_WIDTH-1:0] nxt_q, nxt_d;
    logic                   nxt_v_q, nxt_v_d;
    logic                   promote;

    assign promote = adv_i && nxt_v_q;

    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        nxt_v_d = nxt_v_q;
        if (prime_ld_i) begin
            cur_d = in_dat_i;
        end else if (promote) begin
            cur_d = nxt_q;
        end
        if (nxt_ld_i) begin
            nxt_d = in_dat_i;
        end
        // A refill in the promote cycle keeps the slot occupied.
        if (clr_i) begin
            nxt_v_d = 1'b0;
        end else if (nxt_ld_i) begin
            nxt_v_d = 1'b1;
        end else if (promote) begin
            nxt_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            nxt_v_q <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            nxt_v_q <= nxt_v_d;
        end
    end

    assign cur_o   = cur_q;
    assign nxt_v_o = nxt_v_q;

endmodule

// File: rtl/ifm_fetch_ctrl.sv
// Sequences stream words into the wide-to-narrow parser: init pulse, per-slice reads, one-word prefetch.
// init_word one cycle after the first handshake, reads from the cycle after; pe_ready and a missing next word stall reads.
module ifm_fetch_ctrl
    import acc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    ifm_fetch_ctrl_if.slave bus
);

    fsm_state_t             state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       words_rx_q, words_rx_d;
    logic [TOT_W-1:0]       slices_rd_q, slices_rd_d;
    logic [CNT_W-1:0]       slice_cnt_q, slice_cnt_d;
    logic                   init_q, init_d;

    logic [TOT_W-1:0]       last_idx;
    logic                   s_tready;
    logic                   hs;
    logic                   nxt_v;
    logic                   last_slice;
    logic                   stall;
    logic                   rd;
    logic                   final_rd;
    logic                   start;
    logic [INPUT_WIDTH-1:0] cur;

    assign last_idx   = total_slices(len_q) - TOT_W'(1);
    assign start      = (state_q == ST_IDLE) && bus.conv_start;
    assign hs         = bus.s_tvalid && s_tready;
    assign last_slice = (slice_cnt_q == CNT_W'(MAX_CNT - 1));

    always_comb begin
        s_tready = 1'b0;
        if (state_q == ST_PRIME) begin
            s_tready = 1'b1;
        end else if (state_q == ST_STREAM) begin
            s_tready = !nxt_v && (words_rx_q < len_q);
        end
    end

    // Hold the last slice of a word until its successor is buffered, so fm never runs dry mid-frame.
    assign stall    = last_slice && !nxt_v && (slices_rd_q < last_idx);
    assign rd       = (state_q == ST_STREAM) && bus.pe_ready && !init_q && !stall;
    assign final_rd = rd && (slices_rd_q == last_idx);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_rx_d  = words_rx_q;
        slices_rd_d = slices_rd_q;
        slice_cnt_d = slice_cnt_q;
        init_d      = 1'b0;

        if (hs) begin
            words_rx_d = words_rx_q + LEN_W'(1);
        end
        if (rd) begin
            slice_cnt_d = last_slice ? '0 : slice_cnt_q + CNT_W'(1);
            slices_rd_d = slices_rd_q + TOT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.conv_start) begin
                    len_d       = bus.num_words;
                    words_rx_d  = '0;
                    slices_rd_d = '0;
                    slice_cnt_d = '0;
                    state_d     = (bus.num_words == '0) ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (hs) begin
                    init_d  = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (final_rd) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            words_rx_q  <= '0;
            slices_rd_q <= '0;
            slice_cnt_q <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            words_rx_q  <= words_rx_d;
            slices_rd_q <= slices_rd_d;
            slice_cnt_q <= slice_cnt_d;
            init_q      <= init_d;
        end
    end

    ifm_word_buf u_word_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (start),
        .prime_ld_i ((state_q == ST_PRIME) && hs),
        .nxt_ld_i   ((state_q == ST_STREAM) && hs),
        .adv_i      (rd && last_slice),
        .in_dat_i   (bus.s_tdata),
        .cur_o      (cur),
        .nxt_v_o    (nxt_v)
    );

    assign bus.s_tready  = s_tready;
    assign bus.fm        = cur;
    assign bus.init_word = init_q;
    assign bus.ifm_read  = rd;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ifm_fetch_ctrl.sv
// Directed bench for ifm_fetch_ctrl: frames of 0..3 words, stream gaps, pe backpressure, restart and reset.
module tb_ifm_fetch_ctrl;
    import acc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    ifm_fetch_ctrl_if bus();

    ifm_fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Event log, sampled on the falling edge.
    int cyc        = 0;
    int rd_total   = 0;
    int init_total = 0;
    int done_total = 0;
    int hs_total   = 0;
    int trdy_last  = -1;
    int init_cyc   = -1;
    int done_cyc   = -1;
    logic [INPUT_WIDTH-1:0] init_fm;
    logic [INPUT_WIDTH-1:0] rd_fm  [0:511];
    int                     rd_cyc [0:511];
    int                     hs_cyc [0:511];

    always @(negedge clk) begin
        if (bus.ifm_read) begin
            rd_fm[rd_total]  = bus.fm;
            rd_cyc[rd_total] = cyc;
            rd_total++;
        end
        if (bus.init_word) begin
            init_total++;
            init_cyc = cyc;
            init_fm  = bus.fm;
        end
        if (bus.done) begin
            done_total++;
            done_cyc = cyc;
        end
        if (bus.s_tvalid && bus.s_tready) begin
            hs_cyc[hs_total] = cyc;
            hs_total++;
        end
        if (bus.s_tready) trdy_last = cyc;
        cyc++;
    end

    function automatic logic [INPUT_WIDTH-1:0] mkword(input logic [7:0] b);
        return {(INPUT_WIDTH/8){b}};
    endfunction

    // Returns at #1 after edge N, i.e. in the first cycle following the conv_start edge.
    task automatic start_frame(input logic [LEN_W-1:0] n);
        @(posedge clk); #1;
        bus.conv_start = 1'b1;
        bus.num_words  = n;
        @(posedge clk); #1;
        bus.conv_start = 1'b0;
        bus.num_words  = '0;
    endtask

    // Runs one frame; returns at #1 after the edge that ends the done cycle.
    task automatic drive_frame(input int n, input logic [7:0] base, input int gap_idx,
                               input int gap_len, input bit pe_tog, input int kick_cyc,
                               output bit timed_out);
        int idx, gap_left, c;
        bit fin;
        idx = 0; gap_left = gap_len; c = 0; fin = 1'b0;
        start_frame(LEN_W'(n));
        while (!fin && c < 400) begin
            if (idx == gap_idx && gap_left > 0) begin
                bus.s_tvalid = 1'b0;
                gap_left--;
            end else begin
                bus.s_tvalid = (idx < n);
            end
            bus.s_tdata    = mkword(base + 8'(idx));
            bus.pe_ready   = pe_tog ? c[0] : 1'b1;
            bus.conv_start = (c == kick_cyc);
            bus.num_words  = (c == kick_cyc) ? LEN_W'(9) : '0;
            @(negedge clk);
            if (bus.s_tvalid && bus.s_tready) idx++;
            if (bus.done) fin = 1'b1;
            c++;
            @(posedge clk); #1;
        end
        bus.s_tvalid   = 1'b0;
        bus.pe_ready   = 1'b0;
        bus.conv_start = 1'b0;
        timed_out = !fin;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.conv_start = 1'b0;
        bus.num_words  = '0;
        bus.s_tdata    = '0;
        bus.s_tvalid   = 1'b0;
        bus.pe_ready   = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (bus.s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", bus.s_tready); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
        n_tests++; if (bus.init_word !== 1'b0) begin n_fail++; $display("FAIL reset_init got %b exp 0", bus.init_word); end
        n_tests++; if (bus.ifm_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b exp 0", bus.ifm_read); end
        n_tests++; if (bus.fm !== '0) begin n_fail++; $display("FAIL reset_fm got %h exp 0", bus.fm); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_two_words();
        int r0, i0, d0, h0;
        bit to;
        r0 = rd_total; i0 = init_total; d0 = done_total; h0 = hs_total;
        drive_frame(2, 8'hA0, -1, 0, 1'b0, -1, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL two_timeout got %b exp 0", to); end
        n_tests++; if (rd_total - r0 !== 16) begin n_fail++; $display("FAIL two_reads got %0d exp 16", rd_total - r0); end
        n_tests++; if (init_total - i0 !== 1) begin n_fail++; $display("FAIL two_init_cnt got %0d exp 1", init_total - i0); end
        n_tests++; if (hs_total - h0 !== 2) begin n_fail++; $display("FAIL two_hs got %0d exp 2", hs_total - h0); end
        n_tests++; if (init_cyc !== hs_cyc[h0] + 1) begin n_fail++; $display("FAIL two_init_cyc got %0d exp %0d", init_cyc, hs_cyc[h0] + 1); end
        n_tests++; if (init_fm !== mkword(8'hA0)) begin n_fail++; $display("FAIL two_init_fm got %h exp %h", init_fm, mkword(8'hA0)); end
        n_tests++; if (rd_cyc[r0] !== init_cyc + 1) begin n_fail++; $display("FAIL two_first_rd got %0d exp %0d", rd_cyc[r0], init_cyc + 1); end
        n_tests++; if (rd_cyc[r0+15] - rd_cyc[r0] !== 15) begin n_fail++; $display("FAIL two_gapless got %0d exp 15", rd_cyc[r0+15] - rd_cyc[r0]); end
        for (int k = 0; k < 16; k++) begin
            n_tests++;
            if (rd_fm[r0+k] !== mkword((k < 8) ? 8'hA0 : 8'hA1)) begin
                n_fail++; $display("FAIL two_fm[%0d] got %h exp %h", k, rd_fm[r0+k], mkword((k < 8) ? 8'hA0 : 8'hA1));
            end
        end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL two_done_cnt got %0d exp 1", done_total - d0); end
        n_tests++; if (done_cyc !== rd_cyc[r0+15] + 1) begin n_fail++; $display("FAIL two_done_cyc got %0d exp %0d", done_cyc, rd_cyc[r0+15] + 1); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL two_idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_stream_gap();
        int r0, d0, h0;
        bit to;
        r0 = rd_total; d0 = done_total; h0 = hs_total;
        drive_frame(3, 8'h10, 2, 20, 1'b0, -1, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL gap_timeout got %b exp 0", to); end
        n_tests++; if (rd_total - r0 !== 24) begin n_fail++; $display("FAIL gap_reads got %0d exp 24", rd_total - r0); end
        n_tests++; if (hs_total - h0 !== 3) begin n_fail++; $display("FAIL gap_hs got %0d exp 3", hs_total - h0); end
        n_tests++; if (rd_cyc[r0+15] - rd_cyc[r0+14] <= 1) begin n_fail++; $display("FAIL gap_bubble got %0d exp >1", rd_cyc[r0+15] - rd_cyc[r0+14]); end
        n_tests++; if (rd_cyc[r0+15] !== hs_cyc[h0+2] + 1) begin n_fail++; $display("FAIL gap_resume got %0d exp %0d", rd_cyc[r0+15], hs_cyc[h0+2] + 1); end
        n_tests++; if (rd_fm[r0+15] !== mkword(8'h11)) begin n_fail++; $display("FAIL gap_fm15 got %h exp %h", rd_fm[r0+15], mkword(8'h11)); end
        n_tests++; if (rd_fm[r0+16] !== mkword(8'h12)) begin n_fail++; $display("FAIL gap_fm16 got %h exp %h", rd_fm[r0+16], mkword(8'h12)); end
        n_tests++; if (rd_fm[r0+23] !== mkword(8'h12)) begin n_fail++; $display("FAIL gap_fm23 got %h exp %h", rd_fm[r0+23], mkword(8'h12)); end
        n_tests++; if (rd_cyc[r0+23] - rd_cyc[r0+16] !== 7) begin n_fail++; $display("FAIL gap_tail got %0d exp 7", rd_cyc[r0+23] - rd_cyc[r0+16]); end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL gap_done_cnt got %0d exp 1", done_total - d0); end
        n_tests++; if (done_cyc !== rd_cyc[r0+23] + 1) begin n_fail++; $display("FAIL gap_done_cyc got %0d exp %0d", done_cyc, rd_cyc[r0+23] + 1); end
    endtask

    task automatic test_pe_toggle();
        int r0, d0, h0;
        bit to;
        r0 = rd_total; d0 = done_total; h0 = hs_total;
        drive_frame(1, 8'h5A, -1, 0, 1'b1, -1, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL pe_timeout got %b exp 0", to); end
        n_tests++; if (rd_total - r0 !== 8) begin n_fail++; $display("FAIL pe_reads got %0d exp 8", rd_total - r0); end
        n_tests++; if (hs_total - h0 !== 1) begin n_fail++; $display("FAIL pe_hs got %0d exp 1", hs_total - h0); end
        n_tests++; if (trdy_last !== hs_cyc[h0]) begin n_fail++; $display("FAIL pe_tready_after got %0d exp %0d", trdy_last, hs_cyc[h0]); end
        n_tests++; if (rd_cyc[r0+7] - rd_cyc[r0] !== 14) begin n_fail++; $display("FAIL pe_spacing got %0d exp 14", rd_cyc[r0+7] - rd_cyc[r0]); end
        n_tests++; if (rd_fm[r0] !== mkword(8'h5A)) begin n_fail++; $display("FAIL pe_fm0 got %h exp %h", rd_fm[r0], mkword(8'h5A)); end
        n_tests++; if (rd_fm[r0+7] !== mkword(8'h5A)) begin n_fail++; $display("FAIL pe_fm7 got %h exp %h", rd_fm[r0+7], mkword(8'h5A)); end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL pe_done_cnt got %0d exp 1", done_total - d0); end
    endtask

    task automatic test_zero_len();
        int r0, i0, d0, h0;
        r0 = rd_total; i0 = init_total; d0 = done_total; h0 = hs_total;
        bus.s_tvalid = 1'b1;
        bus.pe_ready = 1'b1;
        bus.s_tdata  = mkword(8'hEE);
        start_frame('0);
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b exp 1", bus.done); end
        n_tests++; if (bus.s_tready !== 1'b0) begin n_fail++; $display("FAIL zero_tready got %b exp 0", bus.s_tready); end
        @(posedge clk); #1;
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b exp 0", bus.done); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle got %b exp 0", bus.busy); end
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        bus.pe_ready = 1'b0;
        n_tests++; if (hs_total - h0 !== 0) begin n_fail++; $display("FAIL zero_hs got %0d exp 0", hs_total - h0); end
        n_tests++; if (init_total - i0 !== 0) begin n_fail++; $display("FAIL zero_init got %0d exp 0", init_total - i0); end
        n_tests++; if (rd_total - r0 !== 0) begin n_fail++; $display("FAIL zero_reads got %0d exp 0", rd_total - r0); end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL zero_done_cnt got %0d exp 1", done_total - d0); end
    endtask

    task automatic test_restart_ignored();
        int r0, d0, h0;
        bit to;
        r0 = rd_total; d0 = done_total; h0 = hs_total;
        drive_frame(2, 8'hC0, -1, 0, 1'b0, 5, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL restart_timeout got %b exp 0", to); end
        n_tests++; if (rd_total - r0 !== 16) begin n_fail++; $display("FAIL restart_reads got %0d exp 16", rd_total - r0); end
        n_tests++; if (hs_total - h0 !== 2) begin n_fail++; $display("FAIL restart_hs got %0d exp 2", hs_total - h0); end
        n_tests++; if (rd_fm[r0+15] !== mkword(8'hC1)) begin n_fail++; $display("FAIL restart_fm got %h exp %h", rd_fm[r0+15], mkword(8'hC1)); end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL restart_done got %0d exp 1", done_total - d0); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle got %b exp 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int r0, d0, i0;
        bit to;
        d0 = done_total;
        bus.pe_ready = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = mkword(8'hB5);
        start_frame(LEN_W'(2));
        repeat (6) @(posedge clk);
        #1;
        n_tests++; if (bus.ifm_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_read got %b exp 1", bus.ifm_read); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.ifm_read !== 1'b0) begin n_fail++; $display("FAIL rstmid_read got %b exp 0", bus.ifm_read); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.s_tready !== 1'b0) begin n_fail++; $display("FAIL rstmid_tready got %b exp 0", bus.s_tready); end
        n_tests++; if (bus.fm !== '0) begin n_fail++; $display("FAIL rstmid_fm got %h exp 0", bus.fm); end
        bus.s_tvalid = 1'b0;
        bus.pe_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (done_total - d0 !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d exp 0", done_total - d0); end
        r0 = rd_total; d0 = done_total; i0 = init_total;
        drive_frame(1, 8'hD0, -1, 0, 1'b0, -1, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout got %b exp 0", to); end
        n_tests++; if (rd_total - r0 !== 8) begin n_fail++; $display("FAIL rstmid_reads got %0d exp 8", rd_total - r0); end
        n_tests++; if (init_total - i0 !== 1) begin n_fail++; $display("FAIL rstmid_init got %0d exp 1", init_total - i0); end
        n_tests++; if (rd_fm[r0+7] !== mkword(8'hD0)) begin n_fail++; $display("FAIL rstmid_fm got %h exp %h", rd_fm[r0+7], mkword(8'hD0)); end
        n_tests++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL rstmid_done got %0d exp 1", done_total - d0); end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_stream_gap();
        test_pe_toggle();
        test_zero_len();
        test_restart_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
